mem_bus_ctrl: RTL

- Memory-side responder on the multi-cycle CPU's memory bus; sits directly downstream of the CPU and consumes its MAB / read_write / initiate_op requests.
- Holds a word-addressed 16-bit RAM and completes each access after a programmable number of wait states.
- Returns read data on the shared tristate MDB and signals completion on op_complete with a four-phase handshake.

---
 rtl/mem_bus_ctrl_if.sv | 27 ++
 rtl/mem_bus_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl_if.sv
// mem_bus_ctrl_if
// Request/acknowledge bundle between the multi-cycle CPU and the memory-side
// responder.
//   MAB          word address from the CPU
//   read_write   1 = read, 0 = write
//   initiate_op  request, held by the CPU until op_complete is seen
//   op_complete  completion acknowledge from memory
//   bus_err      out-of-range access flag from memory
// MDB is not part of this bundle. It is a resolved tristate net shared by
// both sides, so it travels as a plain inout port next to it.
interface mem_bus_ctrl_if;
  logic [15:0] MAB;
  logic        read_write;
  logic        initiate_op;
  logic        op_complete;
  logic        bus_err;

  modport master (
    output MAB, read_write, initiate_op,
    input  op_complete, bus_err
  );

  modport slave (
    input  MAB, read_write, initiate_op,
    output op_complete, bus_err
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl
// Memory-side responder for the multi-cycle CPU bus. Holds a word-addressed
// 16-bit RAM of 2**ADDR_W words and completes each access after WAIT_STATES
// extra ACCESS cycles, acknowledging with a four-phase handshake.
//
// Ports:
//   clk      system clock, all state changes on the rising edge
//   CPU_rst  asynchronous active-high reset, shared with the CPU
//   bus      mem_bus_ctrl_if.slave: MAB, read_write, initiate_op in;
//            op_complete, bus_err out
//   MDB      shared 16-bit data bus; driven only while presenting read
//            data, otherwise high impedance
//
// Build option:
//   MEM_BUS_CTRL_BOUNDS_CHECK_EN  when defined, any MAB bit above
//   ADDR_W-1 marks the access out of range. Writes are dropped, reads return
//   zero, and bus_err accompanies op_complete. When undefined, the upper MAB
//   bits are ignored (addresses alias) and bus_err is always 0.
module mem_bus_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic           clk,
  input  logic           CPU_rst,
  mem_bus_ctrl_if.slave  bus,
  inout  wire  [15:0]    MDB
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_LAST = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rw_q, rw_d;
  logic                oor_q, oor_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [15:0]         rdata_q, rdata_d;
  logic                op_complete_q, op_complete_d;
  logic                drive_q, drive_d;
  logic                bus_err_q, bus_err_d;
  logic                mem_we;
  logic                req_oor;

  logic [15:0]         mem [DEPTH];

`ifdef MEM_BUS_CTRL_BOUNDS_CHECK_EN
  assign req_oor = |bus.MAB[15:ADDR_W];
`else
  // Upper address bits are deliberately dropped so addresses alias.
  logic unused_mab_hi;
  assign unused_mab_hi = ^bus.MAB[15:ADDR_W];
  assign req_oor       = 1'b0;
`endif

  // Next-state logic. op_complete, bus_err and the MDB enable are computed
  // from DONE plus a still-high request, so they rise one edge after DONE is
  // entered and fall on the same edge that returns to IDLE.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rw_d          = rw_q;
    oor_d         = oor_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    op_complete_d = 1'b0;
    drive_d       = 1'b0;
    bus_err_d     = 1'b0;
    mem_we        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.initiate_op) begin
          addr_d  = bus.MAB[ADDR_W-1:0];
          rw_d    = bus.read_write;
          oor_d   = req_oor;
          cnt_d   = 4'd0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!bus.initiate_op) begin
          // Request withdrawn: abandon without touching the RAM.
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
            if (rw_q) begin
              rdata_d = oor_q ? 16'h0000 : mem[addr_q];
            end else begin
              mem_we = ~oor_q;
            end
          end
        end
      end
      DONE: begin
        if (bus.initiate_op) begin
          op_complete_d = 1'b1;
          drive_d       = rw_q;
          bus_err_d     = oor_q;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and handshake registers; reset returns everything to IDLE at
  // once, which also blocks any pending RAM write.
  always_ff @(posedge clk or posedge CPU_rst) begin
    if (CPU_rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      rw_q          <= 1'b0;
      oor_q         <= 1'b0;
      cnt_q         <= 4'd0;
      rdata_q       <= 16'h0000;
      op_complete_q <= 1'b0;
      drive_q       <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rw_q          <= rw_d;
      oor_q         <= oor_d;
      cnt_q         <= cnt_d;
      rdata_q       <= rdata_d;
      op_complete_q <= op_complete_d;
      drive_q       <= drive_d;
      bus_err_q     <= bus_err_d;
    end
  end

  // RAM array, never cleared by reset. mem_we can only be high outside
  // reset because state_q is held at IDLE while CPU_rst is asserted.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= MDB;
    end
  end

  assign bus.op_complete = op_complete_q;
  assign bus.bus_err     = bus_err_q;
  assign MDB             = drive_q ? rdata_q : 16'hzzzz;

endmodule
